// File: rtl/mem_interconnect_arb.sv
// Parametrised N-core memory interconnect: per-core request FIFOs, round-robin
// arbitration into a registered memory request stage, and ID-routed responses.
module mem_interconnect_arb #(
    parameter  int NUM_CORES       = 4,
    parameter  int DATA_W          = 64,
    parameter  int FIFO_DEPTH      = 4,
    parameter  int MAX_OUTSTANDING = 8,
    localparam int ID_W            = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_req_vld,
    input  logic [NUM_CORES*DATA_W-1:0] core_req_data,
    output logic [NUM_CORES-1:0]        core_req_rdy,
    output logic [NUM_CORES-1:0]        core_rsp_vld,
    output logic [DATA_W-1:0]           core_rsp_data,
    output logic                        mem_req_vld,
    output logic [ID_W-1:0]             mem_req_id,
    output logic [DATA_W-1:0]           mem_req_data,
    input  logic                        mem_req_rdy,
    input  logic                        mem_rsp_vld,
    input  logic [ID_W-1:0]             mem_rsp_id,
    input  logic [DATA_W-1:0]           mem_rsp_data,
    output logic                        rsp_id_err,
    output logic [NUM_CORES*8-1:0]      outstanding_cnt
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    logic [DATA_W-1:0]    fifo_mem_r [NUM_CORES][FIFO_DEPTH];
    logic [AW:0]          wr_ptr_r   [NUM_CORES];
    logic [AW:0]          rd_ptr_r   [NUM_CORES];
    logic [7:0]           out_cnt_r  [NUM_CORES];
    logic [NUM_CORES-1:0] full_s, empty_s, eligible_s, push_s, pop_s, dec_s;
    logic [ID_W-1:0]      ptr_r, grant_s, mem_req_id_r;
    logic [DATA_W-1:0]    head_s, mem_req_data_r, core_rsp_data_r;
    logic [NUM_CORES-1:0] core_rsp_vld_r;
    logic                 found_s, load_en_s, load_s, rsp_legal_s, err_set_s;
    logic                 mem_req_vld_r, rsp_id_err_r;

    // FIFO status, push/pop qualification and response decode per core
    always_comb begin
        rsp_legal_s = int'(mem_rsp_id) < NUM_CORES;
        for (int i = 0; i < NUM_CORES; i++) begin
            full_s[i]     = (wr_ptr_r[i] - rd_ptr_r[i]) == (AW+1)'(FIFO_DEPTH);
            empty_s[i]    = wr_ptr_r[i] == rd_ptr_r[i];
            eligible_s[i] = !empty_s[i] && (out_cnt_r[i] < MAX_OUT);
            push_s[i]     = core_req_vld[i] && !full_s[i];
            pop_s[i]      = load_s && (grant_s == ID_W'(i));
            dec_s[i]      = mem_rsp_vld && rsp_legal_s && (mem_rsp_id == ID_W'(i));
        end
    end

    // Round-robin search for the first eligible core at or after ptr
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        grant_s = ptr_r;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(ptr_r) + k) % NUM_CORES;
            if (!found_s && eligible_s[idx]) begin
                found_s = 1'b1;
                grant_s = ID_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
        load_en_s = !mem_req_vld_r || mem_req_rdy;
        load_s    = load_en_s && found_s;
    end

    // Head-of-queue mux for the granted core
    always_comb begin
        head_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_s == ID_W'(i)) begin
                head_s = fifo_mem_r[i][rd_ptr_r[i][AW-1:0]];
            end else begin
                head_s = head_s;
            end
        end
    end

    // Error on an out-of-range ID or a response to a core with nothing in flight
    always_comb begin
        err_set_s = 1'b0;
        if (mem_rsp_vld && !rsp_legal_s) begin
            err_set_s = 1'b1;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (dec_s[i] && (out_cnt_r[i] == 8'd0)) begin
                    err_set_s = 1'b1;
                end else begin
                    err_set_s = err_set_s;
                end
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers qualify them
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (push_s[i]) begin
                fifo_mem_r[i][wr_ptr_r[i][AW-1:0]] <= core_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // FIFO pointers and outstanding counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                wr_ptr_r[i]  <= {(AW+1){1'b0}};
                rd_ptr_r[i]  <= {(AW+1){1'b0}};
                out_cnt_r[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + 1'b1;
                if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + 1'b1;
                case ({pop_s[i], dec_s[i]})
                    2'b10:   out_cnt_r[i] <= out_cnt_r[i] + 8'd1;
                    2'b01:   out_cnt_r[i] <= (out_cnt_r[i] == 8'd0) ? 8'd0 : out_cnt_r[i] - 8'd1;
                    default: out_cnt_r[i] <= out_cnt_r[i];
                endcase
            end
        end
    end

    // Registered memory request stage and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_vld_r  <= 1'b0;
            mem_req_id_r   <= {ID_W{1'b0}};
            mem_req_data_r <= {DATA_W{1'b0}};
            ptr_r          <= {ID_W{1'b0}};
        end else if (load_en_s) begin
            mem_req_vld_r <= found_s;
            if (found_s) begin
                mem_req_id_r   <= grant_s;
                mem_req_data_r <= head_s;
                ptr_r          <= (int'(grant_s) == NUM_CORES - 1) ? {ID_W{1'b0}} : grant_s + 1'b1;
            end
        end
    end

    // Registered response routing and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rsp_vld_r  <= {NUM_CORES{1'b0}};
            core_rsp_data_r <= {DATA_W{1'b0}};
            rsp_id_err_r    <= 1'b0;
        end else begin
            core_rsp_vld_r <= dec_s;
            if (mem_rsp_vld && rsp_legal_s) core_rsp_data_r <= mem_rsp_data;
            if (err_set_s) rsp_id_err_r <= 1'b1;
        end
    end

    assign core_req_rdy  = ~full_s;
    assign core_rsp_vld  = core_rsp_vld_r;
    assign core_rsp_data = core_rsp_data_r;
    assign mem_req_vld   = mem_req_vld_r;
    assign mem_req_id    = mem_req_id_r;
    assign mem_req_data  = mem_req_data_r;
    assign rsp_id_err    = rsp_id_err_r;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
        assign outstanding_cnt[g*8 +: 8] = out_cnt_r[g];
    end
endmodule

// File: tb/tb_mem_interconnect_arb.sv
// Directed bench for mem_interconnect_arb: 3 cores, 16-bit data, depth 4, limit 2.
module tb_mem_interconnect_arb;
    localparam int N  = 3;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    core_req_vld;
    logic [N*DW-1:0] core_req_data;
    logic [N-1:0]    core_req_rdy;
    logic [N-1:0]    core_rsp_vld;
    logic [DW-1:0]   core_rsp_data;
    logic            mem_req_vld;
    logic [1:0]      mem_req_id;
    logic [DW-1:0]   mem_req_data;
    logic            mem_req_rdy;
    logic            mem_rsp_vld;
    logic [1:0]      mem_rsp_id;
    logic [DW-1:0]   mem_rsp_data;
    logic            rsp_id_err;
    logic [N*8-1:0]  outstanding_cnt;

    int total = 0;
    int bad   = 0;

    mem_interconnect_arb #(.NUM_CORES(N), .DATA_W(DW), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset),
        .core_req_vld(core_req_vld), .core_req_data(core_req_data), .core_req_rdy(core_req_rdy),
        .core_rsp_vld(core_rsp_vld), .core_rsp_data(core_rsp_data),
        .mem_req_vld(mem_req_vld), .mem_req_id(mem_req_id), .mem_req_data(mem_req_data),
        .mem_req_rdy(mem_req_rdy), .mem_rsp_vld(mem_rsp_vld), .mem_rsp_id(mem_rsp_id),
        .mem_rsp_data(mem_rsp_data), .rsp_id_err(rsp_id_err), .outstanding_cnt(outstanding_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req_vld  = 3'b000;
        core_req_data = {(N*DW){1'b0}};
        mem_req_rdy   = 1'b1;
        mem_rsp_vld   = 1'b0;
        mem_rsp_id    = 2'd0;
        mem_rsp_data  = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        total++; if (mem_req_vld !== 1'b0) begin bad++; $display("FAIL reset_mem_req_vld got=%b exp=0", mem_req_vld); end
        total++; if (core_rsp_vld !== 3'b000) begin bad++; $display("FAIL reset_core_rsp_vld got=%b exp=000", core_rsp_vld); end
        total++; if (core_rsp_data !== 16'h0000) begin bad++; $display("FAIL reset_core_rsp_data got=%h exp=0000", core_rsp_data); end
        total++; if (rsp_id_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_id_err got=%b exp=0", rsp_id_err); end
        total++; if (outstanding_cnt !== 24'h000000) begin bad++; $display("FAIL reset_outstanding got=%h exp=000000", outstanding_cnt); end
        tick();
        reset = 1'b0;
        tick();
        total++; if (core_req_rdy !== 3'b111) begin bad++; $display("FAIL reset_core_req_rdy got=%b exp=111", core_req_rdy); end
    endtask

    task automatic test_single();
        do_reset();
        core_req_vld = 3'b100; core_req_data[2*DW +: DW] = 16'h00A5;
        tick();
        core_req_vld = 3'b000;
        total++; if (mem_req_vld !== 1'b0) begin bad++; $display("FAIL single_latency got=%b exp=0", mem_req_vld); end
        tick();
        total++; if (mem_req_vld !== 1'b1) begin bad++; $display("FAIL single_vld got=%b exp=1", mem_req_vld); end
        total++; if (mem_req_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d exp=2", mem_req_id); end
        total++; if (mem_req_data !== 16'h00A5) begin bad++; $display("FAIL single_data got=%h exp=00a5", mem_req_data); end
        total++; if (outstanding_cnt[2*8 +: 8] !== 8'd1) begin bad++; $display("FAIL single_cnt_inc got=%0d exp=1", outstanding_cnt[2*8 +: 8]); end
        mem_rsp_vld = 1'b1; mem_rsp_id = 2'd2; mem_rsp_data = 16'h005A;
        tick();
        mem_rsp_vld = 1'b0;
        total++; if (core_rsp_vld !== 3'b100) begin bad++; $display("FAIL single_rsp_vld got=%b exp=100", core_rsp_vld); end
        total++; if (core_rsp_data !== 16'h005A) begin bad++; $display("FAIL single_rsp_data got=%h exp=005a", core_rsp_data); end
        total++; if (outstanding_cnt[2*8 +: 8] !== 8'd0) begin bad++; $display("FAIL single_cnt_dec got=%0d exp=0", outstanding_cnt[2*8 +: 8]); end
        total++; if (mem_req_vld !== 1'b0) begin bad++; $display("FAIL single_req_drain got=%b exp=0", mem_req_vld); end
        tick();
        total++; if (core_rsp_vld !== 3'b000) begin bad++; $display("FAIL single_rsp_pulse got=%b exp=000", core_rsp_vld); end
        total++; if (core_rsp_data !== 16'h005A) begin bad++; $display("FAIL single_rsp_hold got=%h exp=005a", core_rsp_data); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_id;
        do_reset();
        core_req_vld = 3'b111;
        core_req_data = {16'hC002, 16'hC001, 16'hC000};
        tick();
        for (int n = 0; n < 6; n++) begin
            tick();
            exp_id = 2'(n % 3);
            total++; if (mem_req_vld !== 1'b1 || mem_req_id !== exp_id) begin bad++; $display("FAIL fair_grant%0d got=%b/%0d exp=1/%0d", n, mem_req_vld, mem_req_id, exp_id); end
            total++; if (mem_req_data !== {14'h3000, exp_id}) begin bad++; $display("FAIL fair_data%0d got=%h exp=%h", n, mem_req_data, {14'h3000, exp_id}); end
        end
        tick();
        core_req_vld = 3'b000;
        total++; if (mem_req_vld !== 1'b0) begin bad++; $display("FAIL fair_limit_stall got=%b exp=0", mem_req_vld); end
        total++; if (outstanding_cnt !== 24'h020202) begin bad++; $display("FAIL fair_counts got=%h exp=020202", outstanding_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        core_req_vld = 3'b010; core_req_data[DW +: DW] = 16'h0B01;
        tick();
        core_req_vld = 3'b000; mem_req_rdy = 1'b0;
        tick();
        total++; if (mem_req_vld !== 1'b1 || mem_req_id !== 2'd1 || mem_req_data !== 16'h0B01) begin bad++; $display("FAIL bp_load got=%b/%0d/%h exp=1/1/0b01", mem_req_vld, mem_req_id, mem_req_data); end
        for (int k = 0; k < 5; k++) begin
            core_req_vld = 3'b010;
            core_req_data[DW +: DW] = (k < 4) ? 16'(16'h0B02 + k) : 16'h0BFF;
            tick();
            total++; if (mem_req_vld !== 1'b1 || mem_req_id !== 2'd1 || mem_req_data !== 16'h0B01) begin bad++; $display("FAIL bp_stable%0d got=%b/%0d/%h exp=1/1/0b01", k, mem_req_vld, mem_req_id, mem_req_data); end
            total++; if (core_req_rdy[1] !== (k < 3)) begin bad++; $display("FAIL bp_rdy%0d got=%b exp=%b", k, core_req_rdy[1], (k < 3)); end
        end
        core_req_vld = 3'b000; mem_req_rdy = 1'b1;
        tick();
        total++; if (mem_req_vld !== 1'b1 || mem_req_data !== 16'h0B02) begin bad++; $display("FAIL bp_next got=%b/%h exp=1/0b02", mem_req_vld, mem_req_data); end
        total++; if (core_req_rdy[1] !== 1'b1) begin bad++; $display("FAIL bp_rdy_after_pop got=%b exp=1", core_req_rdy[1]); end
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        core_req_vld = 3'b001; core_req_data[0 +: DW] = 16'h0001;
        tick();
        core_req_data[0 +: DW] = 16'h0002;
        tick();
        total++; if (mem_req_vld !== 1'b1 || mem_req_data !== 16'h0001) begin bad++; $display("FAIL lim_first got=%b/%h exp=1/0001", mem_req_vld, mem_req_data); end
        core_req_data[0 +: DW] = 16'h0003;
        tick();
        total++; if (mem_req_vld !== 1'b1 || mem_req_data !== 16'h0002) begin bad++; $display("FAIL lim_second got=%b/%h exp=1/0002", mem_req_vld, mem_req_data); end
        core_req_vld = 3'b000;
        tick();
        total++; if (mem_req_vld !== 1'b0) begin bad++; $display("FAIL lim_block got=%b exp=0", mem_req_vld); end
        total++; if (outstanding_cnt[7:0] !== 8'd2) begin bad++; $display("FAIL lim_cnt got=%0d exp=2", outstanding_cnt[7:0]); end
        tick();
        total++; if (mem_req_vld !== 1'b0) begin bad++; $display("FAIL lim_still_block got=%b exp=0", mem_req_vld); end
        mem_rsp_vld = 1'b1; mem_rsp_id = 2'd0; mem_rsp_data = 16'h1111;
        tick();
        mem_rsp_vld = 1'b0;
        total++; if (mem_req_vld !== 1'b0 || outstanding_cnt[7:0] !== 8'd1) begin bad++; $display("FAIL lim_rsp got=%b/%0d exp=0/1", mem_req_vld, outstanding_cnt[7:0]); end
        tick();
        total++; if (mem_req_vld !== 1'b1 || mem_req_data !== 16'h0003) begin bad++; $display("FAIL lim_third got=%b/%h exp=1/0003", mem_req_vld, mem_req_data); end
        total++; if (outstanding_cnt[7:0] !== 8'd2) begin bad++; $display("FAIL lim_cnt_after got=%0d exp=2", outstanding_cnt[7:0]); end
    endtask

    task automatic test_illegal_id();
        do_reset();
        mem_rsp_vld = 1'b1; mem_rsp_id = 2'd3; mem_rsp_data = 16'hDEAD;
        tick();
        mem_rsp_vld = 1'b0;
        total++; if (core_rsp_vld !== 3'b000) begin bad++; $display("FAIL illegal_no_rsp got=%b exp=000", core_rsp_vld); end
        total++; if (rsp_id_err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", rsp_id_err); end
        total++; if (core_rsp_data !== 16'h0000) begin bad++; $display("FAIL illegal_data_hold got=%h exp=0000", core_rsp_data); end
        tick();
        tick();
        total++; if (rsp_id_err !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%b exp=1", rsp_id_err); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        core_req_vld = 3'b010; core_req_data[DW +: DW] = 16'h0111;
        tick();
        core_req_data[DW +: DW] = 16'h0112;
        tick();
        total++; if (outstanding_cnt[8 +: 8] !== 8'd1) begin bad++; $display("FAIL same_pre_cnt got=%0d exp=1", outstanding_cnt[8 +: 8]); end
        core_req_vld = 3'b000;
        mem_rsp_vld = 1'b1; mem_rsp_id = 2'd1; mem_rsp_data = 16'h0222;
        tick();
        mem_rsp_vld = 1'b0;
        total++; if (outstanding_cnt[8 +: 8] !== 8'd1) begin bad++; $display("FAIL same_cnt got=%0d exp=1", outstanding_cnt[8 +: 8]); end
        total++; if (mem_req_vld !== 1'b1 || mem_req_id !== 2'd1 || mem_req_data !== 16'h0112) begin bad++; $display("FAIL same_req got=%b/%0d/%h exp=1/1/0112", mem_req_vld, mem_req_id, mem_req_data); end
        total++; if (core_rsp_vld !== 3'b010 || rsp_id_err !== 1'b0) begin bad++; $display("FAIL same_rsp got=%b/%b exp=010/0", core_rsp_vld, rsp_id_err); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        mem_req_rdy = 1'b0;
        core_req_vld = 3'b111; core_req_data = {16'hA002, 16'hA001, 16'hA000};
        tick();
        tick();
        mem_rsp_vld = 1'b1; mem_rsp_id = 2'd0; mem_rsp_data = 16'h7777;
        tick();
        mem_rsp_vld = 1'b0; core_req_vld = 3'b000;
        total++; if (mem_req_vld !== 1'b1 || core_rsp_vld !== 3'b001) begin bad++; $display("FAIL mid_pre got=%b/%b exp=1/001", mem_req_vld, core_rsp_vld); end
        reset = 1'b1;
        #2;
        total++; if (mem_req_vld !== 1'b0 || core_rsp_vld !== 3'b000) begin bad++; $display("FAIL mid_async_vld got=%b/%b exp=0/000", mem_req_vld, core_rsp_vld); end
        total++; if (core_rsp_data !== 16'h0000 || outstanding_cnt !== 24'h000000) begin bad++; $display("FAIL mid_async_state got=%h/%h exp=0000/000000", core_rsp_data, outstanding_cnt); end
        tick();
        reset = 1'b0; mem_req_rdy = 1'b1;
        tick();
        total++; if (core_req_rdy !== 3'b111 || mem_req_vld !== 1'b0) begin bad++; $display("FAIL mid_empty got=%b/%b exp=111/0", core_req_rdy, mem_req_vld); end
        mem_rsp_vld = 1'b1; mem_rsp_id = 2'd1; mem_rsp_data = 16'h0BAD;
        tick();
        mem_rsp_vld = 1'b0;
        total++; if (rsp_id_err !== 1'b1 || outstanding_cnt[8 +: 8] !== 8'd0) begin bad++; $display("FAIL mid_stale_rsp got=%b/%0d exp=1/0", rsp_id_err, outstanding_cnt[8 +: 8]); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_outstanding_limit();
        test_illegal_id();
        test_same_cycle();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
